irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_pkg.sv | 28 ++
 rtl/irq_if.sv | 10 +
 rtl/irq_prio_enc.sv | 23 ++
 rtl/irq_ctrl.sv | 109 ++++++++++
 tb/tb_irq_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, source indices
// and vector defaults.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

    localparam int SRC_TRAP  = 0;
    localparam int SRC_INTR  = 1;
    localparam int SRC_UART  = 2;
    localparam int SRC_TIMER = 3;

    localparam logic [7:0] VEC_BASE_DEF   = 8'h10;
    localparam logic [7:0] VEC_STRIDE_DEF = 8'h04;

    // Vector address wraps modulo 256.
    function automatic logic [7:0] vec_calc(input logic [7:0] base,
                                            input logic [7:0] stride,
                                            input logic [7:0] idx);
        logic [15:0] prod;
        prod = idx * stride;
        return base + prod[7:0];
    endfunction

endpackage

// File: rtl/irq_if.sv
// CPU-facing request/acknowledge handshake of the interrupt controller.
interface irq_if;
    logic       irq_req;
    logic [7:0] irq_vec;
    logic       irq_ack;
    logic       irq_done;

    modport master (output irq_req, output irq_vec, input irq_ack, input irq_done);
    modport slave  (input irq_req, input irq_vec, output irq_ack, output irq_done);
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder over the eligible source vector.
module irq_prio_enc #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] eligible,
    output logic [W-1:0] idx,
    output logic         valid
);

    // Scanning downward lets the lowest set bit win.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                idx   = W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-detected sources, fixed priority, one request in
// flight at a time, non-maskable trap on source 0 with sticky double-fault flag.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no request outstanding; arbitrate eligible pending sources
// ST_REQ     | irq_req/irq_vec held for latched sel until irq_ack
// ST_SERVICE | sel in service; wait for irq_done
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int         NSRC       = 4,
    parameter logic [7:0] VEC_BASE   = VEC_BASE_DEF,
    parameter logic [7:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NSRC-1:0] src_in,
    input  logic            cpu_ie,
    input  logic            mask_we,
    input  logic [NSRC-2:0] mask_wdata,
    irq_if.master           bus,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] in_service,
    output logic [NSRC-1:0] mask,
    output logic            double_fault
);

    localparam int IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;

    irq_state_t      state;
    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] gate;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] ack_clr;
    logic [NSRC-1:1] mask_q;
    logic [IDXW-1:0] sel;
    logic [IDXW-1:0] win_idx;
    logic            win_valid;

    assign rise     = src_in & ~src_q;
    assign mask     = {mask_q, 1'b1};
    assign gate     = {{(NSRC-1){cpu_ie}}, 1'b1};
    assign eligible = pending & mask & gate;
    assign ack_clr  = (state == ST_REQ && bus.irq_ack) ? (NSRC'(1) << sel) : '0;

    irq_prio_enc #(.N(NSRC)) u_prio (
        .eligible (eligible),
        .idx      (win_idx),
        .valid    (win_valid)
    );

    // A rising edge in the ack cycle wins over the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q        <= '0;
            pending      <= '0;
            mask_q       <= '0;
            double_fault <= 1'b0;
        end else begin
            src_q   <= src_in;
            pending <= (pending & ~ack_clr) | rise;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
            if (rise[SRC_TRAP] && in_service[SRC_TRAP]) begin
                double_fault <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            sel         <= '0;
            in_service  <= '0;
            bus.irq_req <= 1'b0;
            bus.irq_vec <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        sel         <= win_idx;
                        state       <= ST_REQ;
                        bus.irq_req <= 1'b1;
                        bus.irq_vec <= vec_calc(VEC_BASE, VEC_STRIDE, 8'(win_idx));
                    end
                end
                ST_REQ: begin
                    if (bus.irq_ack) begin
                        in_service[sel] <= 1'b1;
                        state           <= ST_SERVICE;
                        bus.irq_req     <= 1'b0;
                        bus.irq_vec     <= '0;
                    end
                end
                ST_SERVICE: begin
                    if (bus.irq_done) begin
                        in_service <= '0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: behavioural model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_irq_ctrl;

    logic       clk;
    logic       reset_n;
    logic [3:0] src_in;
    logic       cpu_ie;
    logic       mask_we;
    logic [2:0] mask_wdata;
    logic [3:0] pending;
    logic [3:0] in_service;
    logic [3:0] mask;
    logic       double_fault;

    irq_if bus ();

    irq_ctrl #(.NSRC(4), .VEC_BASE(8'h10), .VEC_STRIDE(8'h04)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .src_in       (src_in),
        .cpu_ie       (cpu_ie),
        .mask_we      (mask_we),
        .mask_wdata   (mask_wdata),
        .bus          (bus),
        .pending      (pending),
        .in_service   (in_service),
        .mask         (mask),
        .double_fault (double_fault)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: which sources have unserved events, which one the CPU owns, and
    // whether a request is outstanding or being serviced.
    logic [3:0] m_pend = '0, m_insv = '0, m_mask = 4'b0001, m_prev = '0;
    logic       m_req = 0, m_serv = 0, m_df = 0;
    int         m_sel = 0;
    logic [7:0] m_vec = '0;

    always @(posedge clk or negedge reset_n) begin : model
        logic [3:0] rise, p_old, ins_old, mk_old;
        int pick;
        if (!reset_n) begin
            m_pend = '0; m_insv = '0; m_mask = 4'b0001; m_prev = '0;
            m_req = 0; m_serv = 0; m_df = 0; m_sel = 0; m_vec = '0;
        end else begin
            rise    = src_in & ~m_prev;
            p_old   = m_pend;
            ins_old = m_insv;
            mk_old  = m_mask;
            m_prev  = src_in;
            if (m_req && bus.irq_ack) begin
                m_pend[m_sel] = 1'b0;
                m_insv[m_sel] = 1'b1;
                m_req  = 0;
                m_serv = 1;
            end else if (m_serv && bus.irq_done) begin
                m_insv = '0;
                m_serv = 0;
            end else if (!m_req && !m_serv) begin
                pick = -1;
                for (int i = 0; i < 4; i++)
                    if (pick < 0 && p_old[i] && mk_old[i] && (i == 0 || cpu_ie)) pick = i;
                if (pick >= 0) begin
                    m_sel = pick;
                    m_req = 1;
                    m_vec = 8'((16 + pick * 4) % 256);
                end
            end
            if (rise[0] && ins_old[0]) m_df = 1;
            m_pend = m_pend | rise;
            if (mask_we) m_mask = {mask_wdata, 1'b1};
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc irq_req", bus.irq_req, m_req);
            if (m_req) check("cyc irq_vec", bus.irq_vec, m_vec);
            check("cyc pending", pending, m_pend);
            check("cyc in_service", in_service, m_insv);
            check("cyc mask", mask, m_mask);
            check("cyc double_fault", double_fault, m_df);
        end
    end

    task automatic pulse_src(input logic [3:0] bits);
        src_in = bits;
        @(negedge clk);
        src_in = '0;
    endtask

    task automatic ack();
        bus.irq_ack = 1'b1;
        @(negedge clk);
        bus.irq_ack = 1'b0;
    endtask

    task automatic done();
        bus.irq_done = 1'b1;
        @(negedge clk);
        bus.irq_done = 1'b0;
    endtask

    task automatic write_mask(input logic [2:0] m);
        mask_wdata = m;
        mask_we    = 1'b1;
        @(negedge clk);
        mask_we    = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        while (!bus.irq_req && k < 10) begin
            @(negedge clk);
            k++;
        end
        check({name, " req"}, bus.irq_req, 1);
    endtask

    initial begin
        reset_n = 1'b0; src_in = '0; cpu_ie = 1'b0; mask_we = 1'b0; mask_wdata = '0;
        bus.irq_ack = 1'b0; bus.irq_done = 1'b0;
        repeat (3) @(negedge clk);
        chk_on = 1;
        check("rst irq_req", bus.irq_req, 0);
        check("rst irq_vec", bus.irq_vec, 8'h00);
        check("rst pending", pending, 4'b0000);
        check("rst in_service", in_service, 4'b0000);
        check("rst mask", mask, 4'b0001);
        check("rst double_fault", double_fault, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single maskable source, two-cycle latency, ack and done.
        write_mask(3'b001);
        cpu_ie = 1'b1;
        pulse_src(4'b0010);
        check("s1 req low after 1", bus.irq_req, 0);
        @(negedge clk);
        check("s1 req high after 2", bus.irq_req, 1);
        check("s1 vec", bus.irq_vec, 8'h14);
        ack();
        check("s1 pending1 cleared", pending[1], 0);
        check("s1 in_service", in_service, 4'b0010);
        check("s1 req dropped", bus.irq_req, 0);
        done();
        check("s1 in_service cleared", in_service, 4'b0000);
        ack();
        done();
        check("stray ack/done idle", bus.irq_req, 0);

        // Trap beats source 2 arriving in the same cycle.
        write_mask(3'b111);
        pulse_src(4'b0101);
        @(negedge clk);
        check("s2 trap vec", bus.irq_vec, 8'h10);
        ack();
        done();
        wait_req("s2 uart");
        check("s2 uart vec", bus.irq_vec, 8'h18);
        // Higher-priority arrival and masking do not disturb the held request.
        pulse_src(4'b0010);
        check("s2 no rearb req", bus.irq_req, 1);
        check("s2 no rearb vec", bus.irq_vec, 8'h18);
        write_mask(3'b101);
        check("s2 masked keeps req", bus.irq_req, 1);
        check("s2 masked keeps vec", bus.irq_vec, 8'h18);
        ack();
        done();
        wait_req("s2 intr");
        check("s2 intr vec", bus.irq_vec, 8'h14);
        // Ack coinciding with a fresh edge on the selected source.
        src_in = 4'b0010;
        ack();
        src_in = '0;
        check("s2 pending kept", pending[1], 1);
        check("s2 in_service", in_service, 4'b0010);
        done();
        wait_req("s2 re-request");
        check("s2 re-request vec", bus.irq_vec, 8'h14);
        ack();
        done();

        // cpu_ie gates maskable sources.
        cpu_ie = 1'b0;
        pulse_src(4'b1000);
        repeat (3) @(negedge clk);
        check("s3 gated req", bus.irq_req, 0);
        check("s3 pending3", pending[3], 1);
        cpu_ie = 1'b1;
        wait_req("s3 timer");
        check("s3 timer vec", bus.irq_vec, 8'h1C);
        ack();
        done();

        // Trap while trap in service.
        pulse_src(4'b0001);
        wait_req("s4 trap");
        check("s4 trap vec", bus.irq_vec, 8'h10);
        ack();
        check("s4 in_service", in_service, 4'b0001);
        pulse_src(4'b0001);
        check("s4 double_fault set", double_fault, 1);
        check("s4 trap still pending", pending[0], 1);
        done();
        check("s4 df sticky after done", double_fault, 1);
        wait_req("s4 trap again");
        check("s4 trap again vec", bus.irq_vec, 8'h10);
        ack();
        done();
        check("s4 df sticky", double_fault, 1);

        // Reset in the middle of a request.
        pulse_src(4'b0010);
        wait_req("s5 intr");
        #2;
        reset_n = 1'b0;
        #1;
        check("s5 async req drop", bus.irq_req, 0);
        check("s5 async pending", pending, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("s5 no req after reset", bus.irq_req, 0);
        check("s5 pending after reset", pending, 4'b0000);
        check("s5 df cleared", double_fault, 0);
        check("s5 mask after reset", mask, 4'b0001);

        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
